multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths and encodings are fixed.
REQ-002 The block SHALL have these ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  instruction opcode from the instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC for branches
- mem_ready  in  1  memory handshake, access complete this cycle
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  instruction register load enable
- RegWrite  out  1  register file write enable
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemToReg  out  1  writeback mux select; 1 = memory data
- ALUSrc  out  1  ALU B operand select; 1 = immediate
- Branch  out  1  branch evaluation in progress
- ALUOp  out  2  ALU control class: 00 add, 10 funct-decoded, 11 compare
- InstrDone  out  1  one-cycle pulse when an instruction retires
- Illegal  out  1  sticky illegal-opcode flag
- state  out  3  current state, for debug

Function
REQ-003 States and encodings SHALL be: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=111. Codes 101 and 110 SHALL go to FETCH on the next edge.
REQ-004 Opcode classes SHALL be: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, LUI=0110111. Any other value is illegal.
REQ-005 The class SHALL be latched into an internal register at the DECODE to EXEC edge. EXEC, MEM and WB SHALL use only the latched class; opcode changes after DECODE SHALL have no effect.
REQ-006 Outputs SHALL be decoded from state, latched class, zero and mem_ready. Any output not listed for a state SHALL be 0.
REQ-007 FETCH: MemRead=1.
- mem_ready=0: remain in FETCH.
- mem_ready=1: IRWrite=1 and PCWrite=1 in that cycle; go to DECODE.
REQ-008 DECODE: legal opcode goes to EXEC; illegal opcode goes to TRAP. All control outputs SHALL be 0.
REQ-009 EXEC, per class:
- R: ALUOp=10, ALUSrc=0; go to WB.
- I: ALUOp=10, ALUSrc=1; go to WB.
- LOAD/STORE: ALUOp=00, ALUSrc=1; go to MEM.
- BRANCH: ALUOp=11, ALUSrc=0, Branch=1, PCWrite=zero; go to FETCH with InstrDone=1.
- JAL: ALUOp=10, PCWrite=1; go to WB.
- LUI: ALUOp=10, ALUSrc=0; go to WB.
REQ-010 MEM: ALUSrc=1 and ALUOp=00 held.
- LOAD: MemRead=1. STORE: MemWrite=1.
- Request held while mem_ready=0.
- On mem_ready=1: LOAD goes to WB; STORE goes to FETCH with InstrDone=1.
REQ-011 WB: RegWrite=1 for one cycle; MemToReg=1 only for LOAD; InstrDone=1; go to FETCH.
REQ-012 TRAP: Illegal=1 and all other control outputs 0. TRAP SHALL be exited only by rst.
REQ-013 MemRead and MemWrite SHALL never be 1 in the same cycle. RegWrite and MemWrite SHALL never be 1 in the same cycle.
REQ-014 Latency in cycles (mem_ready=1 immediately):
- R, I, JAL, LUI: 4 (FETCH, DECODE, EXEC, WB).
- BRANCH: 3.
- STORE: 4.
- LOAD: 5.
- Each mem_ready=0 cycle adds 1.
REQ-015 InstrDone SHALL assert exactly once per retired instruction and never in TRAP.

Reset
REQ-016 When rst=1 at a rising edge, state SHALL become FETCH, the latched class SHALL clear, and Illegal SHALL clear. This applies in any state, including mid-MEM with a request outstanding.
REQ-017 While rst=1, all outputs except state SHALL be 0. The first cycle after rst falls SHALL be FETCH with MemRead=1.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- R-type 0110011, mem_ready=1: states 000,001,010,100,000; RegWrite=1 only in WB; ALUOp=10 in EXEC; one InstrDone pulse.
- LOAD 0000011, mem_ready low 2 cycles in MEM: MEM lasts 3 cycles with MemRead=1; WB has MemToReg=1 and RegWrite=1; 7 cycles total.
- BRANCH 1100011 with zero=1, then with zero=0: PCWrite=1 in EXEC for the first, 0 for the second; no WB state; InstrDone in EXEC.
- STORE 0100011: MemWrite=1 in MEM; RegWrite never 1; back to FETCH after mem_ready.
- Illegal opcode 1111111: TRAP (111) entered after DECODE; Illegal=1 held 10 cycles with opcode changing; rst=1 returns to FETCH with Illegal=0.
- rst=1 during MEM with MemWrite=1: next cycle state=000 and MemWrite=0; opcode changed in EXEC does not alter the latched class.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Brief    : Main control unit for a multi-cycle RV32-style datapath.
//             Sequences FETCH/DECODE/EXEC/MEM/WB, traps on illegal opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       ALUSrc,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_LUI    = 3'd7
    } class_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_FN  = 2'b10;
    localparam logic [1:0] c_ALU_CMP = 2'b11;

    state_t     r_state;
    state_t     w_next;
    class_t     r_class;
    class_t     w_dec_class;
    logic       r_illegal;

    logic       w_pcwrite, w_irwrite, w_regwrite, w_memread, w_memwrite;
    logic       w_memtoreg, w_alusrc, w_branch, w_done;
    logic [1:0] w_aluop;

    // Opcode to instruction class; CLS_NONE marks an illegal opcode.
    always_comb begin
        w_dec_class = CLS_NONE;
        case (opcode)
            c_OP_R:      w_dec_class = CLS_R;
            c_OP_I:      w_dec_class = CLS_I;
            c_OP_LOAD:   w_dec_class = CLS_LOAD;
            c_OP_STORE:  w_dec_class = CLS_STORE;
            c_OP_BRANCH: w_dec_class = CLS_BRANCH;
            c_OP_JAL:    w_dec_class = CLS_JAL;
            c_OP_LUI:    w_dec_class = CLS_LUI;
            default:     w_dec_class = CLS_NONE;
        endcase
    end

    // State, latched class and sticky illegal flag; class is captured on
    // leaving DECODE so later opcode changes cannot steer EXEC/MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_class   <= CLS_NONE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_dec_class;
                if (w_dec_class == CLS_NONE) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    // Next-state and control decode from state, latched class and handshakes.
    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = c_ALU_ADD;
        w_done     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                if (mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end else begin
                    w_next    = S_FETCH;
                end
            end
            S_DECODE: begin
                w_next = (w_dec_class == CLS_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (r_class)
                    CLS_R, CLS_LUI: begin
                        w_aluop = c_ALU_FN;
                        w_next  = S_WB;
                    end
                    CLS_I: begin
                        w_aluop  = c_ALU_FN;
                        w_alusrc = 1'b1;
                        w_next   = S_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_aluop  = c_ALU_ADD;
                        w_alusrc = 1'b1;
                        w_next   = S_MEM;
                    end
                    CLS_BRANCH: begin
                        w_aluop   = c_ALU_CMP;
                        w_branch  = 1'b1;
                        w_pcwrite = zero;
                        w_done    = 1'b1;
                        w_next    = S_FETCH;
                    end
                    CLS_JAL: begin
                        w_aluop   = c_ALU_FN;
                        w_pcwrite = 1'b1;
                        w_next    = S_WB;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_alusrc   = 1'b1;
                w_aluop    = c_ALU_ADD;
                w_memread  = (r_class == CLS_LOAD);
                w_memwrite = (r_class == CLS_STORE);
                if ((r_class != CLS_LOAD) && (r_class != CLS_STORE)) begin
                    w_next = S_FETCH;
                end else if (!mem_ready) begin
                    w_next = S_MEM;
                end else if (r_class == CLS_LOAD) begin
                    w_next = S_WB;
                end else begin
                    w_done = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = (r_class == CLS_LOAD);
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Controls are forced low while reset is held, whatever the state.
    assign PCWrite   = w_pcwrite  & ~rst;
    assign IRWrite   = w_irwrite  & ~rst;
    assign RegWrite  = w_regwrite & ~rst;
    assign MemRead   = w_memread  & ~rst;
    assign MemWrite  = w_memwrite & ~rst;
    assign MemToReg  = w_memtoreg & ~rst;
    assign ALUSrc    = w_alusrc   & ~rst;
    assign Branch    = w_branch   & ~rst;
    assign ALUOp     = w_aluop & {2{~rst}};
    assign InstrDone = w_done     & ~rst;
    assign Illegal   = r_illegal  & ~rst;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Brief    : Cycle-by-cycle vector bench for multicycle_control_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg;
    logic       ALUSrc, Branch, InstrDone, Illegal;
    logic [1:0] ALUOp;
    logic [2:0] state;

    multicycle_control_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemToReg  (MemToReg),
        .ALUSrc    (ALUSrc),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .InstrDone (InstrDone),
        .Illegal   (Illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector bit positions:
    // {PCWrite,IRWrite,RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,Branch,ALUOp[1:0],InstrDone,Illegal}
    localparam logic [11:0] PCW  = 12'h800;
    localparam logic [11:0] IRW  = 12'h400;
    localparam logic [11:0] RW   = 12'h200;
    localparam logic [11:0] MR   = 12'h100;
    localparam logic [11:0] MW   = 12'h080;
    localparam logic [11:0] M2R  = 12'h040;
    localparam logic [11:0] ALUS = 12'h020;
    localparam logic [11:0] BR   = 12'h010;
    localparam logic [11:0] AFN  = 12'h008;
    localparam logic [11:0] ACMP = 12'h00C;
    localparam logic [11:0] DONE = 12'h002;
    localparam logic [11:0] ILL  = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [2:0] SF = 3'b000, SD = 3'b001, SE = 3'b010;
    localparam logic [2:0] SM = 3'b011, SW = 3'b100, ST = 3'b111;

    typedef struct {
        string       tag;
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        mr;
        logic [2:0]  st;
        logic [11:0] ctl;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input string tag, input logic r, input logic [6:0] op,
                       input logic z, input logic mr, input logic [2:0] st,
                       input logic [11:0] ctl);
        vec_t v;
        v.tag = tag; v.rst = r; v.op = op; v.z = z; v.mr = mr;
        v.st = st; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    // Scoreboard checker: compares the oldest expected record each cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            vec_t        e;
            logic [11:0] act;
            e   = sb.pop_front();
            act = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemToReg,
                   ALUSrc, Branch, ALUOp, InstrDone, Illegal};
            n_vec++;
            if ({state, act} !== {e.st, e.ctl}) begin
                n_bad++;
                $display("FAIL vec%0d %s: state=%b ctl=%b, expected state=%b ctl=%b",
                         n_vec, e.tag, state, act, e.st, e.ctl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;

        // Reset: all controls low, state FETCH.
        add("rst0", 1, OP_R, 0, 0, SF, NONE);
        add("rst1", 1, OP_R, 0, 1, SF, NONE);

        // R-type, no stalls: 4 cycles.
        add("r_f",  0, OP_R, 0, 1, SF, PCW | IRW | MR);
        add("r_d",  0, OP_R, 0, 1, SD, NONE);
        add("r_e",  0, OP_R, 0, 1, SE, AFN);
        add("r_w",  0, OP_R, 0, 1, SW, RW | DONE);
        // I-type.
        add("i_f",  0, OP_I, 0, 1, SF, PCW | IRW | MR);
        add("i_d",  0, OP_I, 0, 1, SD, NONE);
        add("i_e",  0, OP_I, 0, 1, SE, AFN | ALUS);
        add("i_w",  0, OP_I, 0, 1, SW, RW | DONE);
        // JAL.
        add("j_f",  0, OP_JAL, 0, 1, SF, PCW | IRW | MR);
        add("j_d",  0, OP_JAL, 0, 1, SD, NONE);
        add("j_e",  0, OP_JAL, 0, 1, SE, AFN | PCW);
        add("j_w",  0, OP_JAL, 0, 1, SW, RW | DONE);
        // LUI.
        add("u_f",  0, OP_LUI, 0, 1, SF, PCW | IRW | MR);
        add("u_d",  0, OP_LUI, 0, 1, SD, NONE);
        add("u_e",  0, OP_LUI, 0, 1, SE, AFN);
        add("u_w",  0, OP_LUI, 0, 1, SW, RW | DONE);

        // Fetch stall, then LOAD with two MEM wait cycles (7 cycles after fetch).
        add("ld_fs", 0, OP_LD, 0, 0, SF, MR);
        add("ld_f",  0, OP_LD, 0, 1, SF, PCW | IRW | MR);
        add("ld_d",  0, OP_LD, 0, 1, SD, NONE);
        add("ld_e",  0, OP_LD, 0, 1, SE, ALUS);
        add("ld_m0", 0, OP_LD, 0, 0, SM, ALUS | MR);
        add("ld_m1", 0, OP_LD, 0, 0, SM, ALUS | MR);
        add("ld_m2", 0, OP_LD, 0, 1, SM, ALUS | MR);
        add("ld_w",  0, OP_LD, 0, 1, SW, RW | M2R | DONE);

        // BRANCH taken, then not taken: 3 cycles, retires in EXEC.
        add("bt_f",  0, OP_BR, 0, 1, SF, PCW | IRW | MR);
        add("bt_d",  0, OP_BR, 0, 1, SD, NONE);
        add("bt_e",  0, OP_BR, 1, 1, SE, ACMP | BR | PCW | DONE);
        add("bn_f",  0, OP_BR, 0, 1, SF, PCW | IRW | MR);
        add("bn_d",  0, OP_BR, 0, 1, SD, NONE);
        add("bn_e",  0, OP_BR, 0, 1, SE, ACMP | BR | DONE);

        // STORE with one MEM wait; retires from MEM.
        add("st_f",  0, OP_ST, 0, 1, SF, PCW | IRW | MR);
        add("st_d",  0, OP_ST, 0, 1, SD, NONE);
        add("st_e",  0, OP_ST, 0, 1, SE, ALUS);
        add("st_m0", 0, OP_ST, 0, 0, SM, ALUS | MW);
        add("st_m1", 0, OP_ST, 0, 1, SM, ALUS | MW | DONE);

        // STORE whose opcode changes in EXEC, then reset mid-MEM.
        add("sr_f",  0, OP_ST, 0, 1, SF, PCW | IRW | MR);
        add("sr_d",  0, OP_ST, 0, 1, SD, NONE);
        add("sr_e",  0, OP_R,  0, 1, SE, ALUS);
        add("sr_m",  0, OP_R,  0, 0, SM, ALUS | MW);
        add("sr_rst",1, OP_R,  0, 0, SM, NONE);
        add("sr_f2", 0, OP_R,  0, 0, SF, MR);

        // Illegal opcode: TRAP held 10 cycles with changing inputs, then reset.
        add("il_f",  0, OP_BAD, 0, 1, SF, PCW | IRW | MR);
        add("il_d",  0, OP_BAD, 0, 1, SD, NONE);
        add("il_t0", 0, OP_R,   0, 1, ST, ILL);
        add("il_t1", 0, OP_LD,  1, 0, ST, ILL);
        add("il_t2", 0, OP_ST,  0, 1, ST, ILL);
        add("il_t3", 0, OP_BR,  1, 1, ST, ILL);
        add("il_t4", 0, OP_JAL, 0, 0, ST, ILL);
        add("il_t5", 0, OP_LUI, 1, 1, ST, ILL);
        add("il_t6", 0, OP_I,   0, 0, ST, ILL);
        add("il_t7", 0, OP_BAD, 1, 1, ST, ILL);
        add("il_t8", 0, 7'h00,  0, 1, ST, ILL);
        add("il_t9", 0, 7'h55,  1, 0, ST, ILL);
        add("il_rst",1, OP_R,   0, 0, ST, NONE);
        add("il_f2", 0, OP_R,   0, 0, SF, MR);
        add("il_f3", 0, OP_R,   0, 1, SF, PCW | IRW | MR);
        add("il_d3", 0, OP_R,   0, 1, SD, NONE);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst       = tbl[i].rst;
            opcode    = tbl[i].op;
            zero      = tbl[i].z;
            mem_ready = tbl[i].mr;
            sb.push_back(tbl[i]);
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0 || n_vec != tbl.size()) begin
            n_bad++;
            $display("FAIL drain: checked=%0d pending=%0d, expected checked=%0d pending=0",
                     n_vec, sb.size(), tbl.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
